// File: rtl/ct_f_spsram_1024x59_ctrl.sv
// Request-side controller for a 1024x59 single-port SRAM wrapper: clears the array
// after reset or on demand, then serves single-cycle reads and bit-masked writes.
//
// state | meaning
// INIT  | writing INIT_VAL to entry init_cnt, one entry per cycle
// RUN   | serving client reads/writes, response held under back-pressure
module ct_f_spsram_1024x59_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 59,
  parameter int DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bwen,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  req_acc;
  logic                  rd_acc;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // The counter wraps to zero after the last entry, so it is already cleared for the next INIT.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end else begin
      init_cnt <= '0;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rsp_vld <= 1'b0;
    end else if (rd_acc) begin
      rsp_vld <= 1'b1;
    end else if (rsp_rdy) begin
      rsp_vld <= 1'b0;
    end
  end

  // The wrapper holds Q while CEN is high, so read data needs no local register.
  assign rsp_rdata = sram_q;

  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    req_rdy   = 1'b0;
    req_acc   = 1'b0;
    rd_acc    = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = init_cnt;
        sram_d    = INIT_VAL;
        if (init_cnt == LAST_ADDR) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        req_rdy = !rsp_vld || rsp_rdy;
        req_acc = req_vld && req_rdy;
        rd_acc  = req_acc && !req_wr;
        if (req_acc) begin
          sram_cen = 1'b0;
          sram_a   = req_addr;
          if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = req_bwen;
            sram_d    = req_wdata;
          end
        end
        // A clear may only start once no response is owed and the port is idle.
        if (init_start && !rsp_vld && !req_acc) begin
          state_nxt = INIT;
        end
      end
      default: state_nxt = INIT;
    endcase
    // Keep the SRAM deselected while reset is asserted, even though state reads INIT.
    if (!cpurst_b) begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
    end
  end

endmodule

// File: tb/tb_ct_f_spsram_1024x59_ctrl.sv
// Bench for ct_f_spsram_1024x59_ctrl: behavioural SRAM wrapper, array/queue reference
// model, directed scenarios followed by randomized traffic.
module tb_ct_f_spsram_1024x59_ctrl;

  localparam int AW = 10;
  localparam int DW = 59;
  localparam int DEPTH = 1024;

  logic          forever_cpuclk = 1'b0;
  logic          cpurst_b;
  logic          init_start;
  logic          init_busy;
  logic          req_vld;
  logic          req_rdy;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_bwen;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] rsp_q [$];

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_f_spsram_1024x59_ctrl dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .init_start     (init_start),
    .init_busy      (init_busy),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_bwen       (req_bwen),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // SRAM wrapper: Q registered on read, held otherwise; array seeded with garbage.
  logic [DW-1:0] sram_arr [DEPTH];
  bit            seeded = 1'b0;
  always @(posedge forever_cpuclk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) sram_arr[i] = DW'({$urandom, $urandom});
      seeded = 1'b1;
    end
    if (!sram_cen) begin
      if (sram_gwen) sram_q <= sram_arr[sram_a];
      else sram_arr[sram_a] = (sram_arr[sram_a] & sram_wen) | (sram_d & ~sram_wen);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Entered at a falling edge with the controller clearing; optional reset pulse mid-clear.
  task automatic wait_init(input int abort_at);
    int n = 0;
    int bad = 0;
    int abort = abort_at;
    while (init_busy && n < DEPTH + 100) begin
      #2;
      if (sram_a != n[AW-1:0] || sram_cen || sram_gwen || sram_wen != '0 || sram_d != '0 || req_rdy)
        bad++;
      if (n == abort) begin
        cpurst_b = 1'b0;
        #1;
        check("rst_mid_cen", sram_cen, 1);
        check("rst_mid_busy", init_busy, 1);
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        abort = -1;
        n = 0;
        bad = 0;
        continue;
      end
      @(negedge forever_cpuclk);
      n++;
    end
    check("init_len", n, DEPTH);
    check("init_seq", bad, 0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    rsp_q.delete();
  endtask

  task automatic do_cycle(input bit vld, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] bwen,
                          input bit rdy, input bit ini = 1'b0, input int abort_at = -1);
    bit exp_vld, exp_rdy, acc, start_init;
    req_vld = vld; req_wr = wr; req_addr = addr; req_wdata = wdata; req_bwen = bwen;
    rsp_rdy = rdy; init_start = ini;
    #2;
    exp_vld = (rsp_q.size() != 0);
    check("rsp_vld", rsp_vld, exp_vld);
    if (exp_vld) check("rsp_rdata", rsp_rdata, rsp_q[0]);
    exp_rdy = !exp_vld || rdy;
    check("req_rdy", req_rdy, exp_rdy);
    check("init_busy", init_busy, 0);
    acc = vld && exp_rdy;
    if (acc) begin
      check("sram_cen_acc", sram_cen, 0);
      check("sram_a", sram_a, addr);
      if (wr) begin
        check("sram_gwen_wr", sram_gwen, 0);
        check("sram_wen_wr", sram_wen, bwen);
        check("sram_d", sram_d, wdata);
      end else begin
        check("sram_gwen_rd", sram_gwen, 1);
        check("sram_wen_rd", sram_wen, {DW{1'b1}});
      end
    end else begin
      check("sram_cen_idle", sram_cen, 1);
    end
    if (exp_vld && rdy) void'(rsp_q.pop_front());
    start_init = ini && !exp_vld && !acc;
    if (acc) begin
      if (wr) mem_m[addr] = (mem_m[addr] & bwen) | (wdata & ~bwen);
      else rsp_q.push_back(mem_m[addr]);
    end
    @(negedge forever_cpuclk);
    req_vld = 1'b0; init_start = 1'b0;
    if (start_init) wait_init(abort_at);
  endtask

  task automatic idle(input bit rdy);
    do_cycle(1'b0, 1'b0, '0, '0, '1, rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ones, part_bwen;
    ones = '1;
    part_bwen = {{(DW-29){1'b1}}, 29'b0};
    cpurst_b = 1'b0; init_start = 1'b0; req_vld = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wdata = '0; req_bwen = '1; rsp_rdy = 1'b1;
    repeat (3) @(negedge forever_cpuclk);
    #2;
    check("rst_busy", init_busy, 1);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_cen", sram_cen, 1);
    check("rst_rsp_vld", rsp_vld, 0);
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    wait_init(-1);

    do_cycle(1, 0, 10'h3FF, '0, '1, 1);
    idle(1);
    do_cycle(1, 1, 10'h155, 59'h5A5A5A5A5A5A5A5, '0, 1);
    do_cycle(1, 0, 10'h155, '0, '1, 1);
    idle(1);
    do_cycle(1, 1, 10'h155, ones, part_bwen, 1);
    do_cycle(1, 0, 10'h155, '0, '1, 1);
    idle(1);
    do_cycle(1, 0, 10'h001, '0, '1, 1);
    do_cycle(1, 0, 10'h002, '0, '1, 1);
    do_cycle(1, 0, 10'h003, '0, '1, 1);
    idle(1);

    do_cycle(1, 0, 10'h155, '0, '1, 1);
    for (int i = 0; i < 3; i++) do_cycle(1, 1, 10'h155, '0, '0, 0);
    do_cycle(1, 0, 10'h002, '0, '1, 1);
    // Write to the address just read while its response is being consumed.
    do_cycle(1, 1, 10'h002, 59'h123, '0, 1);
    idle(1);

    do_cycle(1, 0, 10'h155, '0, '1, 1);
    do_cycle(0, 0, '0, '0, '1, 0, 1);
    idle(0);
    idle(1);

    do_cycle(0, 0, '0, '0, '1, 1, 1, 500);
    do_cycle(1, 0, 10'h155, '0, '1, 1);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
               DW'({$urandom, $urandom}), DW'({$urandom, $urandom}),
               $urandom_range(0, 3) != 0);
    end
    idle(1);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
